// File: rtl/sync_queue_if.sv
// Push/pop bus between a producer/consumer pair and sync_queue.
// The AlFull/AlEmpty signals exist only when QUEUE_ALMOST_EN is defined.
interface sync_queue_if #(
  parameter int bitPerWord  = 8,
  parameter int bitOfColumn = 5
);
  logic                   Push;
  logic [bitPerWord-1:0]  DataIn;
  logic                   Pop;
  logic                   Clr;
  logic [bitPerWord-1:0]  DataOut;
  logic                   DataValid;
  logic [bitOfColumn:0]   Count;
  logic                   Empty;
  logic                   Full;
  logic                   Overflow;
  logic                   Underflow;
`ifdef QUEUE_ALMOST_EN
  logic                   AlFull;
  logic                   AlEmpty;
`endif

  // Producer/consumer side
  modport master (
    output Push, DataIn, Pop, Clr,
    input  DataOut, DataValid, Count, Empty, Full, Overflow, Underflow
`ifdef QUEUE_ALMOST_EN
    , input AlFull, AlEmpty
`endif
  );

  // Queue side
  modport slave (
    input  Push, DataIn, Pop, Clr,
    output DataOut, DataValid, Count, Empty, Full, Overflow, Underflow
`ifdef QUEUE_ALMOST_EN
    , output AlFull, AlEmpty
`endif
  );
endinterface

// File: rtl/sync_queue.sv
// Synchronous FIFO of 2^bitOfColumn words with registered read, occupancy count and sticky
// error flags. Optional almost-full/almost-empty flags are enabled by QUEUE_ALMOST_EN.
module sync_queue #(
  parameter int bitPerWord  = 8,
  parameter int bitOfColumn = 5
`ifdef QUEUE_ALMOST_EN
  ,
  parameter int alFullTh    = 28,
  parameter int alEmptyTh   = 4
`endif
) (
  input  logic            Clk,
  input  logic            Rst_n,
  sync_queue_if.slave     q
);

  localparam logic [bitOfColumn:0]   DEPTH_C = {1'b1, {bitOfColumn{1'b0}}};
  localparam logic [bitOfColumn-1:0] PTR_ONE = {{(bitOfColumn-1){1'b0}}, 1'b1};
  localparam logic [bitOfColumn:0]   CNT_ONE = {{bitOfColumn{1'b0}}, 1'b1};

  logic [bitPerWord-1:0]  mem_q [2**bitOfColumn];

  logic [bitOfColumn-1:0] wr_ptr_q, wr_ptr_d;
  logic [bitOfColumn-1:0] rd_ptr_q, rd_ptr_d;
  logic [bitOfColumn:0]   count_q, count_d;
  logic                   empty_q, empty_d;
  logic                   full_q, full_d;
  logic [bitPerWord-1:0]  data_out_q;
  logic                   data_valid_q, data_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;

  logic                   push_acc;
  logic                   pop_acc;
  logic                   wr_en;

  // A full queue still accepts a push when a pop frees a slot in the same cycle;
  // an empty queue never forwards the incoming word straight to the output.
  assign push_acc = q.Push & (~full_q | q.Pop);
  assign pop_acc  = q.Pop & ~empty_q;
  assign wr_en    = Rst_n & ~q.Clr & push_acc;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (q.Clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      data_valid_d = pop_acc;

      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      if (q.Push & ~push_acc) overflow_d  = 1'b1;
      if (q.Pop & ~pop_acc)   underflow_d = 1'b1;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= q.DataIn;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      // Read sees the pre-write word, so a full push+pop returns the oldest entry.
      if (pop_acc && !q.Clr) data_out_q <= mem_q[rd_ptr_q];
    end
  end

  assign q.DataOut   = data_out_q;
  assign q.DataValid = data_valid_q;
  assign q.Count     = count_q;
  assign q.Empty     = empty_q;
  assign q.Full      = full_q;
  assign q.Overflow  = overflow_q;
  assign q.Underflow = underflow_q;

`ifdef QUEUE_ALMOST_EN
  localparam logic [bitOfColumn:0] AL_FULL_TH  = (bitOfColumn+1)'(alFullTh);
  localparam logic [bitOfColumn:0] AL_EMPTY_TH = (bitOfColumn+1)'(alEmptyTh);

  logic al_full_q;
  logic al_empty_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      al_full_q  <= 1'b0;
      al_empty_q <= 1'b1;
    end else begin
      al_full_q  <= (count_d >= AL_FULL_TH);
      al_empty_q <= (count_d <= AL_EMPTY_TH);
    end
  end

  assign q.AlFull  = al_full_q;
  assign q.AlEmpty = al_empty_q;
`endif

endmodule

// File: tb/tb_sync_queue.sv
// Directed bench for sync_queue: a table of single-cycle vectors plus hand-written
// sequences for fill/overflow, full push+pop, pointer wrap, reset and flush.
module tb_sync_queue;

  localparam int BPW = 8;
  localparam int BOC = 5;

  logic Clk = 1'b0;
  logic Rst_n;

  sync_queue_if #(.bitPerWord(BPW), .bitOfColumn(BOC)) qif ();

  sync_queue #(.bitPerWord(BPW), .bitOfColumn(BOC)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .q     (qif.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst_n;
    logic       clr;
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic [5:0] cnt;
    logic       emp;
    logic       ful;
    logic       dv;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t tbl [13];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [7:0] model [$];
  logic [7:0] exp_w;
  int   next_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic c, input logic p, input logic [7:0] d,
                      input logic po);
    @(negedge Clk);
    Rst_n      = r;
    qif.Clr    = c;
    qif.Push   = p;
    qif.DataIn = d;
    qif.Pop    = po;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push_w(input logic [7:0] d);
    step(1'b1, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk({name, "_dv"}, 32'(qif.DataValid), 32'd1);
    chk({name, "_data"}, 32'(qif.DataOut), 32'(exp));
  endtask

  initial begin
    Rst_n = 1'b0; qif.Clr = 1'b0; qif.Push = 1'b0; qif.DataIn = '0; qif.Pop = 1'b0;

    //            rst clr push din    pop  cnt emp ful dv dout   ovf unf
    tbl[0]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 6'd0,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b1,8'd7, 1'b0, 6'd1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b1,8'd30,1'b0, 6'd2,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b1,8'd14,1'b0, 6'd3,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 6'd2,1'b0,1'b0,1'b1,8'd7, 1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 6'd1,1'b0,1'b0,1'b1,8'd30,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 6'd0,1'b1,1'b0,1'b1,8'd14,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 6'd0,1'b1,1'b0,1'b0,8'd14,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 6'd0,1'b1,1'b0,1'b0,8'd14,1'b0,1'b1};
    tbl[9]  = '{1'b1,1'b0,1'b1,8'd5, 1'b1, 6'd1,1'b0,1'b0,1'b0,8'd14,1'b0,1'b1};
    tbl[10] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 6'd0,1'b1,1'b0,1'b1,8'd5, 1'b0,1'b1};
    tbl[11] = '{1'b0,1'b0,1'b1,8'hAA,1'b1, 6'd0,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 6'd0,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst_n, tbl[i].clr, tbl[i].push, tbl[i].din, tbl[i].pop);
      chk("count",     32'(qif.Count),     32'(tbl[i].cnt));
      chk("empty",     32'(qif.Empty),     32'(tbl[i].emp));
      chk("full",      32'(qif.Full),      32'(tbl[i].ful));
      chk("valid",     32'(qif.DataValid), 32'(tbl[i].dv));
      chk("dataout",   32'(qif.DataOut),   32'(tbl[i].dout));
      chk("overflow",  32'(qif.Overflow),  32'(tbl[i].ovf));
      chk("underflow", 32'(qif.Underflow), 32'(tbl[i].unf));
      $display("vec %0d: push=%0b din=%0d pop=%0b -> count=%0d dv=%0b dout=%0d",
               i, tbl[i].push, tbl[i].din, tbl[i].pop, qif.Count, qif.DataValid, qif.DataOut);
    end

    // Fill to capacity, overflow, drain in order.
    do_reset();
    for (int i = 0; i < 32; i++) push_w(8'(i));
    chk("fill_count", 32'(qif.Count), 32'd32);
    chk("fill_full",  32'(qif.Full),  32'd1);
    push_w(8'd99);
    chk("ovf_flag",   32'(qif.Overflow), 32'd1);
    chk("ovf_count",  32'(qif.Count),    32'd32);
    for (int i = 0; i < 32; i++) pop_chk("drain", 8'(i));
    chk("drain_empty", 32'(qif.Empty), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("drain_idle_dv", 32'(qif.DataValid), 32'd0);
    $display("seq fill/overflow/drain done");

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 32; i++) push_w(8'(100 + i));
    step(1'b1, 1'b0, 1'b1, 8'd77, 1'b1);
    chk("fullpp_dv",    32'(qif.DataValid), 32'd1);
    chk("fullpp_data",  32'(qif.DataOut),   32'd100);
    chk("fullpp_count", 32'(qif.Count),     32'd32);
    chk("fullpp_full",  32'(qif.Full),      32'd1);
    for (int i = 1; i < 32; i++) pop_chk("fullpp_drain", 8'(100 + i));
    pop_chk("fullpp_last", 8'd77);
    chk("fullpp_empty", 32'(qif.Empty), 32'd1);
    $display("seq full push+pop done");

    // Repeated half-drain/refill across many pointer wraps.
    next_val = 0;
    model.delete();
    for (int i = 0; i < 32; i++) begin
      push_w(8'(next_val)); model.push_back(8'(next_val)); next_val++;
    end
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) begin
        exp_w = model.pop_front();
        pop_chk("wrap", exp_w);
      end
      for (int i = 0; i < 16; i++) begin
        push_w(8'(next_val)); model.push_back(8'(next_val)); next_val++;
      end
      chk("wrap_count", 32'(qif.Count), 32'd32);
    end
    while (model.size() > 0) begin
      exp_w = model.pop_front();
      pop_chk("wrap_tail", exp_w);
    end
    chk("wrap_empty", 32'(qif.Empty), 32'd1);
    $display("seq wrap done");

    // Reset mid-operation while pushing.
    do_reset();
    for (int i = 0; i < 10; i++) push_w(8'(50 + i));
    chk("pre_rst_count", 32'(qif.Count), 32'd10);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
    chk("rst_count", 32'(qif.Count),    32'd0);
    chk("rst_empty", 32'(qif.Empty),    32'd1);
    chk("rst_dout",  32'(qif.DataOut),  32'd0);
    chk("rst_ovf",   32'(qif.Overflow), 32'd0);
    push_w(8'h11);
    chk("rst_next_count", 32'(qif.Count), 32'd1);
    pop_chk("rst_next", 8'h11);
    $display("seq reset mid-operation done");

    // Flush with sticky overflow set.
    do_reset();
    for (int i = 0; i < 32; i++) push_w(8'(200 + i));
    push_w(8'd50);
    chk("clr_pre_ovf", 32'(qif.Overflow), 32'd1);
    pop_chk("clr_pre", 8'd200);
    push_w(8'd33);
    chk("clr_pre_count", 32'(qif.Count), 32'd32);
    step(1'b1, 1'b1, 1'b1, 8'd44, 1'b1);
    chk("clr_count", 32'(qif.Count),     32'd0);
    chk("clr_empty", 32'(qif.Empty),     32'd1);
    chk("clr_full",  32'(qif.Full),      32'd0);
    chk("clr_dv",    32'(qif.DataValid), 32'd0);
    chk("clr_dout",  32'(qif.DataOut),   32'd200);
    chk("clr_ovf",   32'(qif.Overflow),  32'd1);
    chk("clr_unf",   32'(qif.Underflow), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_post_dv",  32'(qif.DataValid), 32'd0);
    chk("clr_post_unf", 32'(qif.Underflow), 32'd1);
    $display("seq flush done");

`ifdef QUEUE_ALMOST_EN
    do_reset();
    chk("al_rst_full",  32'(qif.AlFull),  32'd0);
    chk("al_rst_empty", 32'(qif.AlEmpty), 32'd1);
    for (int i = 0; i < 27; i++) push_w(8'(i));
    chk("al_27_full",  32'(qif.AlFull),  32'd0);
    chk("al_27_empty", 32'(qif.AlEmpty), 32'd0);
    push_w(8'd27);
    chk("al_28_full",  32'(qif.AlFull),  32'd1);
    for (int i = 0; i < 23; i++) pop_chk("al_drain", 8'(i));
    chk("al_5_empty", 32'(qif.AlEmpty), 32'd0);
    chk("al_5_full",  32'(qif.AlFull),  32'd0);
    pop_chk("al_drain4", 8'd23);
    chk("al_4_empty", 32'(qif.AlEmpty), 32'd1);
    $display("seq almost flags done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
